// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word fetches to a
// synchronous instruction memory, buffers returns in a 2-entry queue and
// presents them to decode with valid/ready backpressure. Redirects from EX
// flush the queue and drop any fetch still in flight.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  logic [31:0] pc_q;
  logic [31:0] inflight_pc_q;
  logic        inflight_q;
  logic        squash_q;

  logic [1:0]  count_q;
  logic [31:0] q0_pc_q, q0_instr_q;
  logic [31:0] q1_pc_q, q1_instr_q;

  logic [1:0]  occ;
  logic        pop;
  logic        push;
  logic        issue;

  assign imem_pc  = pc_q & ~32'h3;

  assign if_valid = (count_q != 2'd0);
  assign if_pc    = if_valid ? q0_pc_q    : 32'h0;
  assign if_instr = if_valid ? q0_instr_q : NOP_INSTR;

  // Slots in use: queued entries plus the one fetch that may be in flight.
  // The issue rule keeps this at most 2, so the queue can never overflow.
  assign occ   = count_q + {1'b0, inflight_q};
  // A redirect flushes the queue, so a handshake on that edge is discarded.
  assign pop   = if_valid && id_ready && !redirect_valid;
  // The squash flag is a guard on the return path; a redirect also drops
  // the return landing on its own edge because the queue is being flushed.
  assign push  = inflight_q && !squash_q && !redirect_valid;
  assign issue = !redirect_valid && ((occ < 2'd2) || ((occ == 2'd2) && pop));

  // PC and in-flight tracking: issue, advance, or jump to a redirect target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= 32'h0;
      inflight_q    <= 1'b0;
      squash_q      <= 1'b0;
    end else begin
      squash_q <= redirect_valid;
      if (redirect_valid) begin
        pc_q       <= redirect_pc & ~32'h3;
        inflight_q <= 1'b0;
      end else if (issue) begin
        inflight_q    <= 1'b1;
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 32'd4;
      end else begin
        inflight_q <= 1'b0;
      end
    end
  end

  // Two-entry FIFO, entry 0 is the head; simultaneous push and pop honoured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= 2'd0;
      q0_pc_q    <= 32'h0;
      q0_instr_q <= 32'h0;
      q1_pc_q    <= 32'h0;
      q1_instr_q <= 32'h0;
    end else if (redirect_valid) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            q0_pc_q    <= inflight_pc_q;
            q0_instr_q <= imem_instr;
          end else begin
            q1_pc_q    <= inflight_pc_q;
            q1_instr_q <= imem_instr;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          q0_pc_q    <= q1_pc_q;
          q0_instr_q <= q1_instr_q;
          count_q    <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            q0_pc_q    <= inflight_pc_q;
            q0_instr_q <= imem_instr;
          end else begin
            q0_pc_q    <= q1_pc_q;
            q0_instr_q <= q1_instr_q;
            q1_pc_q    <= inflight_pc_q;
            q1_instr_q <= imem_instr;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A return must always find a free slot.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count_q == 2'd2)));
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: cycle-by-cycle vector table covering
// startup, stall, redirects and PC wrap, plus an asynchronous reset and
// restart sequence. A small synchronous memory model serves fetches.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int n_vec  = 0;
  int n_miss = 0;

  if_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a function of the word index the model decodes.
  function automatic logic [31:0] word_at(input logic [5:0] idx);
    case (idx)
      6'd0:    return 32'h0050_0093;
      6'd1:    return 32'h00A0_0113;
      6'd2:    return 32'h0020_81B3;
      default: return 32'hF000_0000 | {24'h0, idx, 2'b00};
    endcase
  endfunction

  logic [31:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = word_at(i[5:0]);
  end

  always @(posedge clk) imem_instr <= mem[imem_pc[7:2]];

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    logic [31:0] eimem;
  } vec_t;

  vec_t tbl[$];
  vec_t rtbl[$];

  function automatic vec_t mk(input logic rdy, input logic redir, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                              input logic [31:0] eimem);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.ev = ev; v.epc = ev ? epc : 32'h0; v.ein = ev ? ein : NOP; v.eimem = eimem;
    return v;
  endfunction

  task automatic check(input string name, input logic ev, input logic [31:0] epc,
                       input logic [31:0] ein, input logic [31:0] eimem);
    n_vec++;
    if (if_valid !== ev || if_pc !== epc || if_instr !== ein || imem_pc !== eimem) begin
      n_miss++;
      $display("FAIL %s: got valid=%0b pc=%h instr=%h imem_pc=%h, want valid=%0b pc=%h instr=%h imem_pc=%h",
               name, if_valid, if_pc, if_instr, imem_pc, ev, epc, ein, eimem);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    rst            = 1'b1;
    id_ready       = v.rdy;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    @(posedge clk);
    #1;
    check(name, v.ev, v.epc, v.ein, v.eimem);
  endtask

  initial begin
    // Startup: first issue at edge 1, first valid after edge 2.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h4));
    tbl.push_back(mk(1, 0, 0, 1, 32'h0, 32'h0050_0093, 32'h8));
    // Stall five cycles: head held, queue fills with 0,4, imem_pc frozen at 8.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 1, 32'h0, 32'h0050_0093, 32'h8));
    // Release: 4 then 8 with no gap.
    tbl.push_back(mk(1, 0, 0, 1, 32'h4, 32'h00A0_0113, 32'hC));
    tbl.push_back(mk(1, 0, 0, 1, 32'h8, 32'h0020_81B3, 32'h10));
    // Redirect to 0x40 with 8 queued and C in flight, decode stalled.
    tbl.push_back(mk(0, 1, 32'h40, 0, 0, 0, 32'h40));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h44));
    tbl.push_back(mk(1, 0, 0, 1, 32'h40, 32'hF000_0040, 32'h48));
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'hF000_0044, 32'h4C));
    // Misaligned target 0x42 coinciding with a pop of 0x44.
    tbl.push_back(mk(1, 1, 32'h42, 0, 0, 0, 32'h40));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h44));
    tbl.push_back(mk(1, 0, 0, 1, 32'h40, 32'hF000_0040, 32'h48));
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'hF000_0044, 32'h4C));
    // Back-to-back redirects: the second target wins.
    tbl.push_back(mk(1, 1, 32'h80, 0, 0, 0, 32'h80));
    tbl.push_back(mk(1, 1, 32'h20, 0, 0, 0, 32'h20));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h24));
    tbl.push_back(mk(1, 0, 0, 1, 32'h20, 32'hF000_0020, 32'h28));
    tbl.push_back(mk(1, 0, 0, 1, 32'h24, 32'hF000_0024, 32'h2C));
    // PC wrap from 0xFFFFFFFC to 0.
    tbl.push_back(mk(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 1, 32'hFFFF_FFFC, 32'hF000_00FC, 32'h4));
    tbl.push_back(mk(1, 0, 0, 1, 32'h0, 32'h0050_0093, 32'h8));
    tbl.push_back(mk(1, 0, 0, 1, 32'h4, 32'h00A0_0113, 32'hC));

    // Restart after async reset: same timing as startup, then streaming.
    rtbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h4));
    rtbl.push_back(mk(1, 0, 0, 1, 32'h0, 32'h0050_0093, 32'h8));
    rtbl.push_back(mk(1, 0, 0, 1, 32'h4, 32'h00A0_0113, 32'hC));
    rtbl.push_back(mk(1, 0, 0, 1, 32'h8, 32'h0020_81B3, 32'h10));

    rst            = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #2;
    check("reset_state", 1'b0, 32'h0, NOP, 32'h0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Assert reset between edges while the pipe is streaming.
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 1'b0, 32'h0, NOP, 32'h0);

    for (int i = 0; i < rtbl.size(); i++) apply(rtbl[i], $sformatf("restart%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end of the RV32IM pipeline IF stage. It is the requester side of the instruction-memory interface.
- It owns the PC register and drives the word-address PC into the synchronous instruction memory. That memory returns the instruction one clock edge after the PC is sampled.
- It buffers returned instructions in a 2-entry queue and hands them to the IF/ID boundary with valid/ready backpressure.
- It handles branch/jump redirects from EX by squashing in-flight and queued fetches.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- NOP_INSTR, 32'h00000013, value driven on if_instr when no valid instruction is present (ADDI x0,x0,0).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- imem_pc  output  32  fetch address to instruction memory; sampled by imem at the rising edge.
- imem_instr  input  32  instruction returned by imem; valid in the cycle after the edge that sampled imem_pc.
- id_ready  input  1  decode can accept this cycle; low means stall.
- redirect_valid  input  1  taken branch/jump from EX, single-cycle pulse.
- redirect_pc  input  32  redirect target.
- if_valid  output  1  if_pc/if_instr hold a valid instruction.
- if_pc  output  32  PC of the presented instruction.
- if_instr  output  32  presented instruction.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_q=RESET_PC; in-flight flag and squash flag cleared.
  - Queue empty, so if_valid=0, if_pc=0, if_instr=NOP_INSTR; imem_pc=RESET_PC.
  - Reset asserted mid-operation discards all queued and in-flight state immediately.
- imem_pc = {pc_q[31:2],2'b00}, combinational.
- Fetch slots:
  - Issue occurs at a rising edge when rst=1, redirect_valid=0, and (count + inflight) < 2, or (count + inflight) == 2 and a pop happens at the same edge.
  - On issue: inflight_q<=1, inflight_pc_q<=pc_q, pc_q<=pc_q+4 (mod 2^32 wrap, no overflow flag).
  - No issue: inflight_q<=0, pc_q holds.
- Return: if inflight_q=1 and not squashed at a rising edge, push {inflight_pc_q, imem_instr} into the queue tail.
- Queue:
  - 2 entries, FIFO order; count range 0..2; push and pop at the same edge are both honoured.
  - Push never occurs when full; the issue rule guarantees this. Assert in simulation.
- Output:
  - if_valid = count!=0. Head entry drives if_pc/if_instr; NOP_INSTR and if_pc=0 when empty.
  - Pop when if_valid && id_ready. Output stays stable while if_valid && !id_ready.
- Latency:
  - Issue at edge k, push at edge k+1, if_valid visible after edge k+1.
  - First instruction after reset release: if_valid rises after the 2nd rising edge.
  - Steady state with id_ready=1: one instruction per cycle, consecutive PCs.
- Redirect (redirect_valid=1 at an edge):
  - Queue cleared (any pop that edge is ignored).
  - Current in-flight fetch is squashed: its data is not pushed next edge.
  - pc_q<=redirect_pc with bits[1:0] forced to 0. No issue at this edge.
  - Target is issued at the next edge and appears on if_valid 2 edges after the redirect edge.
  - Back-to-back redirects: the last one wins.
- Stall: with id_ready=0, the queue fills to 2 and issue stops. The PC after the last issued one is held in pc_q; nothing is lost or duplicated.

Test Plan:
- Reset release, RESET_PC=0, imem preloaded 00500093,00A00113,002081B3 -> if_valid rises after edge 2; (pc,instr) = (0,00500093),(4,00A00113),(8,002081B3) on consecutive cycles.
- id_ready=0 for 5 cycles after the first valid -> if_pc holds 0; queue holds PCs 0,4; imem_pc frozen at 8; on release PCs 0,4,8,C stream with no gap or duplicate.
- redirect_valid pulse with redirect_pc=0x40 while PCs 8/C are queued/in-flight -> neither 8 nor C is presented; next valid is if_pc=0x40 two edges later, then 0x44.
- redirect_pc=0x42 -> fetches 0x40; imem_pc low bits 0.
- redirect coinciding with pop and id_ready=1 -> the popped entry is consumed once; no stale entry appears afterwards.
- rst asserted asynchronously mid-stream (between edges) -> if_valid=0, if_instr=00000013, imem_pc=RESET_PC immediately; restart timing identical to the first scenario.
